// File: rtl/sha3_theta_apply.sv
// sha3_theta_apply: applies the SHA-3 theta column terms to a 5x5x64 state.
// An accepted state rides an ELT_LATENCY-deep delay line so it meets the
// matching theta elts (ielt) from the external elts stage; each row element
// is XORed with its column term and the result is registered.
//
// Build option: define SHA3_THETA_APPLY_SKID_EN to add a FIFO_DEPTH-entry
// output FIFO with out_ready backpressure. Default build has no FIFO and
// ignores out_ready.
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   in_valid / in_ready      input state handshake
//   isa..ise [4:0][63:0]     input rows a..e, element [c] = column c
//   sample                   pulse to the elts stage on accept
//   ielt [4:0][63:0]         theta elts, valid ELT_LATENCY cycles after sample
//   out_valid / out_ready    output handshake
//   osa..ose [4:0][63:0]     theta-applied rows
module sha3_theta_apply #(
   parameter int ELT_LATENCY = 1,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0][63:0] isa,
   input  logic [4:0][63:0] isb,
   input  logic [4:0][63:0] isc,
   input  logic [4:0][63:0] isd,
   input  logic [4:0][63:0] ise,
   output logic             sample,
   input  logic [4:0][63:0] ielt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [4:0][63:0] osa,
   output logic [4:0][63:0] osb,
   output logic [4:0][63:0] osc,
   output logic [4:0][63:0] osd,
   output logic [4:0][63:0] ose
);
   // [row][col][bit]
   typedef logic [4:0][4:0][63:0] state_t;

   state_t in_st, exit_st, xr, os;
   logic   accept, exit_vld;
   logic   rdy_en_q;

   assign in_st  = {ise, isd, isc, isb, isa};
   assign {ose, osd, osc, osb, osa} = os;
   assign accept = in_valid && in_ready;
   assign sample = accept;

`ifdef SHA3_THETA_APPLY_SKID_EN
   localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   logic [CW-1:0] inflight;
`endif

   // in_ready may only rise on the first edge after reset release
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rdy_en_q <= 1'b0;
      else        rdy_en_q <= 1'b1;

   // Delay line: never stalls, the elts stage cannot be held off
   generate
      if (ELT_LATENCY == 0) begin : g_nodly
         assign exit_vld = accept;
         assign exit_st  = in_st;
`ifdef SHA3_THETA_APPLY_SKID_EN
         assign inflight = '0;
`endif
      end else begin : g_dly
         logic [ELT_LATENCY-1:0] vld_pipe_q;
         state_t                 st_q [ELT_LATENCY];

         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) vld_pipe_q <= '0;
            else begin
               vld_pipe_q[0] <= accept;
               for (int s = 1; s < ELT_LATENCY; s++) vld_pipe_q[s] <= vld_pipe_q[s-1];
            end

         always_ff @(posedge clk) begin
            st_q[0] <= in_st;
            for (int s = 1; s < ELT_LATENCY; s++) st_q[s] <= st_q[s-1];
         end

         assign exit_vld = vld_pipe_q[ELT_LATENCY-1];
         assign exit_st  = st_q[ELT_LATENCY-1];
`ifdef SHA3_THETA_APPLY_SKID_EN
         // accepted states not yet in the FIFO
         always_comb begin
            inflight = '0;
            for (int s = 0; s < ELT_LATENCY; s++) inflight = inflight + CW'(vld_pipe_q[s]);
         end
`endif
      end
   endgenerate

   always_comb begin
      xr = exit_st;
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            xr[r][c] = exit_st[r][c] ^ ielt[c];
   end

`ifdef SHA3_THETA_APPLY_SKID_EN
   // FIFO storage doubles as the result register
   state_t        fifo_q [FIFO_DEPTH];
   logic [PW-1:0] wp_q, rp_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          wr, rd;

   assign wr        = exit_vld;
   assign rd        = out_valid && out_ready;
   assign out_valid = (cnt_q != '0);
   assign os        = fifo_q[rp_q];
   // reserve a slot for every state already in the delay line
   assign in_ready  = rdy_en_q && ((cnt_q + inflight) < CW'(FIFO_DEPTH));

   always_comb begin
      cnt_d = cnt_q;
      case ({wr, rd})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt_q <= '0;
         wp_q  <= '0;
         rp_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (wr) wp_q <= (wp_q == PW'(FIFO_DEPTH - 1)) ? '0 : wp_q + PW'(1);
         if (rd) rp_q <= (rp_q == PW'(FIFO_DEPTH - 1)) ? '0 : rp_q + PW'(1);
      end

   always_ff @(posedge clk)
      if (wr) fifo_q[wp_q] <= xr;

   a_no_full_write: assert property (@(posedge clk) disable iff (!rst_n)
                                     !(wr && cnt_q == CW'(FIFO_DEPTH)));
`else
   state_t res_q;
   logic   res_vld_q;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) res_vld_q <= 1'b0;
      else        res_vld_q <= exit_vld;

   always_ff @(posedge clk)
      if (exit_vld) res_q <= xr;

   assign out_valid = res_vld_q;
   assign os        = res_q;
   assign in_ready  = rdy_en_q;
`endif

endmodule
